// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle ALU.
//   Request : in_valid, in_ready, a, b, alu_control
//   Response: out_valid, out_ready, result, hi, lo, zero, overflow, div_by_zero
//   master = control unit side, slave = ALU side.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, alu_control, out_ready,
    input  in_ready, out_valid, result, hi, lo, zero, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, alu_control, out_ready,
    output in_ready, out_valid, result, hi, lo, zero, overflow, div_by_zero
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake on both sides.
//   Single-cycle ops: AND OR ADD SLTU XOR NOR SUB SLT (result one cycle after accept).
//   MULU (shift-add) and DIVU (restoring) iterate WIDTH cycles; {hi,lo} = product,
//   or hi = remainder / lo = quotient.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - alu_mc_if.slave (request, response and status flags)
// Build option: ALU_MC_SIGNED_MULDIV_EN adds signed MUL (1010) and DIV (1011).
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
`ifdef ALU_MC_SIGNED_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
`endif
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, m_q, m_d;
  logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;

  logic             in_ready, accept;
  logic             is_mul, is_div, signed_op;
  logic [WIDTH-1:0] a_mag, b_mag, sum, dif, alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;

  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // Operation decode and single-cycle datapath
  always_comb begin
    is_mul    = (bus.alu_control == OP_MULU);
    is_div    = (bus.alu_control == OP_DIVU);
    signed_op = 1'b0;
`ifdef ALU_MC_SIGNED_MULDIV_EN
    if (bus.alu_control == OP_MUL) begin
      is_mul    = 1'b1;
      signed_op = 1'b1;
    end
    if (bus.alu_control == OP_DIV) begin
      is_div    = 1'b1;
      signed_op = 1'b1;
    end
`endif
    // Signed mul/div runs on magnitudes; signs are restored on the last iteration
    a_mag = (signed_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (signed_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;

    sum     = bus.a + bus.b;
    dif     = bus.a - bus.b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.alu_control)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = '0;
    endcase
  end

  // One iteration step. acc_hi/acc_lo form a 2*WIDTH shift register: for MUL it is
  // {partial product, remaining multiplier}, for DIV {partial remainder, dividend/quotient}.
  // With a zero divisor every trial subtraction succeeds, which naturally yields
  // quotient = all ones and remainder = dividend.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, m_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
    prod = neg_lo_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    if (is_div_q) begin
      fin_lo = neg_lo_q ? -step_lo : step_lo;
      fin_hi = neg_hi_q ? -step_hi : step_hi;
    end else begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state / output-register logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    m_d        = m_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_pend_d = dbz_pend_q;
    result_d   = result_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul | is_div) begin
            state_d    = BUSY;
            cnt_d      = '0;
            is_div_d   = is_div;
            m_d        = is_mul ? a_mag : b_mag;
            acc_hi_d   = '0;
            acc_lo_d   = is_mul ? b_mag : a_mag;
            // A zero divisor keeps the unsigned all-ones quotient regardless of sign
            neg_lo_d   = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (is_mul | (bus.b != '0));
            neg_hi_d   = signed_op & bus.a[WIDTH-1] & is_div;
            dbz_pend_d = is_div & (bus.b == '0);
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            hi_d     = '0;
            lo_d     = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            dbz_d    = 1'b0;
          end
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = fin_lo;
          hi_d     = fin_hi;
          lo_d     = fin_lo;
          zero_d   = (fin_lo == '0);
          ovf_d    = 1'b0;
          dbz_d    = dbz_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      m_q        <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      result_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      m_q        <= m_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_pend_q <= dbz_pend_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;

endmodule
